// File: rtl/tt_ternary_pkg.sv
// Shared types and helpers for the ternary matrix-vector multiply stage.
// Weight codes, FSM states, accumulator sizing and output saturation.
package tt_ternary_pkg;

    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;
    localparam logic [1:0] W_ZERO = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    function automatic int acc_width(input int in_len, input int data_w);
        return data_w + $clog2(in_len);
    endfunction

    // Clamp to the signed range of a data_w-bit result.
    function automatic logic signed [31:0] saturate(
        input logic signed [31:0] a,
        input int                 data_w
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (data_w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (a > hi)
            return hi;
        else if (a < lo)
            return lo;
        else
            return a;
    endfunction

endpackage

// File: rtl/tt_um_mac_lane.sv
// One output column: decode a ternary weight and add, subtract or hold.
// The first sample of a vector starts from zero instead of the old sum.
module tt_um_mac_lane
    import tt_ternary_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic                     i_first,
    input  logic [1:0]               i_w,
    input  logic signed [DATA_W-1:0] i_x,
    output logic signed [ACC_W-1:0]  o_acc
);

    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_delta;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] r_acc;

    assign w_ext  = ACC_W'(i_x);
    assign w_base = i_first ? '0 : r_acc;
    assign o_acc  = r_acc;

    // 2'b10 is a reserved code and never contributes.
    always_comb begin
        w_delta = '0;
        case (i_w)
            W_POS:   w_delta = w_ext;
            W_NEG:   w_delta = -w_ext;
            W_ZERO:  w_delta = '0;
            default: w_delta = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_acc <= '0;
        else if (i_en)
            r_acc <= w_base + w_delta;
    end

endmodule

// File: rtl/tt_um_mult.sv
// Ternary matrix-vector multiply: streams activations into per-column
// accumulators, then drains saturated results one per enabled cycle.
module tt_um_mult
    import tt_ternary_pkg::*;
#(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int DATA_W      = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ena,
    input  logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights,
    input  logic [6:0]                          ui_param,
    input  logic                                in_valid,
    input  logic [DATA_W-1:0]                   ui_act,
    output logic                                uo_busy,
    output logic                                uo_valid,
    output logic [DATA_W-1:0]                   uo_data,
    output logic [2:0]                          uo_idx,
    output logic                                uo_done
);

    localparam int ACC_W = acc_width(MAX_IN_LEN, DATA_W);

    state_t             r_state;
    logic [3:0]         r_count;
    logic [3:0]         r_last_row;
    logic [2:0]         r_last_col;
    logic [2:0]         r_didx;
    logic               r_busy;
    logic               r_valid;
    logic               r_done;
    logic [DATA_W-1:0]  r_data;
    logic [2:0]         r_idx;

    logic                    w_accept;
    logic                    w_first;
    logic [1:0]              w_row [MAX_OUT_LEN];
    logic signed [ACC_W-1:0] w_acc [MAX_OUT_LEN];
    logic signed [ACC_W-1:0] w_sel;
    logic [DATA_W-1:0]       w_sat;

    assign w_accept = ena & in_valid & (r_state != DRAIN);
    assign w_first  = (r_state == IDLE);

    // Row select: the weights of the row matching the current sample.
    always_comb begin
        for (int j = 0; j < MAX_OUT_LEN; j++) begin
            w_row[j] = ui_weights[2*(int'(r_count)*MAX_OUT_LEN + j) +: 2];
        end
    end

    for (genvar g = 0; g < MAX_OUT_LEN; g++) begin : g_lane
        tt_um_mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_en    (w_accept),
            .i_first (w_first),
            .i_w     (w_row[g]),
            .i_x     (ui_act),
            .o_acc   (w_acc[g])
        );
    end

    assign w_sel = w_acc[r_didx];
    assign w_sat = DATA_W'(saturate(32'(w_sel), DATA_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_last_row <= '0;
            r_last_col <= '0;
            r_didx     <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_data     <= '0;
            r_idx      <= '0;
        end else if (!ena) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_last_row <= ui_param[6:3];
                        r_last_col <= ui_param[2:0];
                        r_didx     <= '0;
                        r_busy     <= 1'b1;
                        if (ui_param[6:3] == 4'd0) begin
                            r_state <= DRAIN;
                            r_count <= '0;
                        end else begin
                            r_state <= ACCUM;
                            r_count <= 4'd1;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (r_count == r_last_row) begin
                            r_state <= DRAIN;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    r_valid <= 1'b1;
                    r_data  <= w_sat;
                    r_idx   <= r_didx;
                    if (r_didx == r_last_col) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_didx  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_didx <= r_didx + 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign uo_busy  = r_busy;
    assign uo_valid = r_valid;
    assign uo_data  = r_data;
    assign uo_idx   = r_idx;
    assign uo_done  = r_done;

endmodule
